// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor step per clock,
// LSB first, behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             br_reg, br_next;
    logic             bout_reg, bout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Single full-subtractor cell working on the current LSBs.
    logic x_bit, y_bit, d_bit, borrow_new;
    assign x_bit      = sa_reg[0];
    assign y_bit      = sb_reg[0];
    assign d_bit      = x_bit ^ y_bit ^ br_reg;
    assign borrow_new = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_reg);

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        acc_next   = acc_reg;
        diff_next  = diff_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        bout_next  = bout_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    sa_next    = a;
                    sb_next    = b;
                    br_next    = bin;
                    cnt_next   = '0;
                    acc_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                acc_next = {d_bit, acc_reg[WIDTH-1:1]};
                br_next  = borrow_new;
                cnt_next = cnt_reg + CW'(1);
                // Last bit: publish result on the same edge that leaves RUN.
                if (cnt_reg == CNT_LAST) begin
                    diff_next  = {d_bit, acc_reg[WIDTH-1:1]};
                    bout_next  = borrow_new;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            acc_reg   <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            bout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            acc_reg   <= acc_next;
            diff_reg  <= diff_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
            bout_reg  <= bout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model
// ({bout,diff} = {0,a} - b - bin), including handshake timing and reset abort.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done, bout;
    logic [7:0] diff;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [7:0] last_diff = 8'h00;
    logic       last_bout = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] ref_sub(input logic [7:0] ra, input logic [7:0] rb,
                                           input logic rbin);
        return {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] la, input logic [7:0] lb, input logic lbin);
        a = la; b = lb; bin = lbin; start = 1'b1;
    endtask

    // Follows an op from its accepting edge to the done cycle; poke >= 0 pulses
    // start and scrambles the operands during that RUN cycle.
    task automatic collect(input string tag, input logic [8:0] expv, input int poke);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            check({tag, " hold"}, {23'd0, last_bout, last_diff} ^ 32'd0, {23'd0, bout, diff});
            start = (i == poke);
            if (i == poke) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        check({tag, " result"}, {23'd0, bout, diff}, {23'd0, expv});
        last_diff = expv[7:0];
        last_bout = expv[8];
        exp_done++;
        $display("op %s: a-b-bin -> diff=%02h bout=%0b (expected %02h/%0b)",
                 tag, diff, bout, expv[7:0], expv[8]);
    endtask

    task automatic idle_gap(input string tag);
        @(negedge clk);
        check({tag, " done_width"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic op(input string tag, input logic [7:0] la, input logic [7:0] lb,
                      input logic lbin, input int poke);
        launch(la, lb, lbin);
        collect(tag, ref_sub(la, lb, lbin), poke);
        idle_gap(tag);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rbin;
        rst_n = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        rst_n = 1'b1;

        // First start right after reset release.
        op("basic", 8'h05, 8'h03, 1'b0, -1);
        op("under1", 8'h03, 8'h05, 1'b0, -1);
        op("under2", 8'h00, 8'h01, 1'b0, -1);
        op("bin_msb", 8'h80, 8'h00, 1'b1, -1);
        op("bin_zero", 8'h00, 8'h00, 1'b1, -1);
        check("const under2", 32'(ref_sub(8'h00, 8'h01, 1'b0)), 32'h1FF);

        // Back-to-back: second start accepted in the DONE cycle of the first.
        launch(8'h10, 8'h01, 1'b0);
        collect("b2b_first", ref_sub(8'h10, 8'h01, 1'b0), -1);
        launch(8'hFF, 8'hFF, 1'b0);
        collect("b2b_second", ref_sub(8'hFF, 8'hFF, 1'b0), -1);
        idle_gap("b2b");

        op("ignored_start", 8'h37, 8'h9C, 1'b1, 3);

        // Reset asynchronously in the fourth RUN cycle, between clock edges.
        launch(8'h5A, 8'h21, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        #1 rst_n = 1'b1;
        last_diff = 8'h00;
        last_bout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort no_done", 32'(done), 32'd0);
        end
        op("after_abort", 8'hC3, 8'h3C, 1'b1, -1);

        // Random operands, randomly mixing back-to-back and gapped starts.
        for (int n = 0; n < 160; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            launch(ra, rb, rbin);
            collect("rand", ref_sub(ra, rb, rbin), -1);
            if ($urandom_range(0, 1) == 1) idle_gap("rand");
        end
        idle_gap("final");

        check("done_count", 32'(done_cnt), 32'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
